// File: rtl/fpnew_wrap_pkg.sv
// rtl/fpnew_wrap_pkg.sv - shared types for the FPNew wrapper blocks
package fpnew_wrap_pkg;

  localparam int unsigned STATUS_WIDTH  = 5;
  localparam int unsigned ROB_TAG_WIDTH = 2;

  // Same bit order as the fpnew status vector, NV in the MSB
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef logic [ROB_TAG_WIDTH:0] rob_ptr_t;

endpackage

// File: rtl/fpnew_rob_slot.sv
// rtl/fpnew_rob_slot.sv - one reorder-buffer entry: alloc/done flags plus result and status
module fpnew_rob_slot
  import fpnew_wrap_pkg::*;
#(
  parameter int unsigned FLEN         = 64,
  parameter int unsigned STATUS_WIDTH = fpnew_wrap_pkg::STATUS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    alloc_i,
  input  logic                    write_i,
  input  logic                    retire_i,
  input  logic [FLEN-1:0]         result_i,
  input  logic [STATUS_WIDTH-1:0] status_i,
  output logic                    alloc_o,
  output logic                    done_o,
  output logic [FLEN-1:0]         result_o,
  output logic [STATUS_WIDTH-1:0] status_o
);

  logic                    alloc_q, alloc_d;
  logic                    done_q, done_d;
  logic [FLEN-1:0]         result_q;
  logic [STATUS_WIDTH-1:0] status_q;

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (flush_i) begin
      alloc_d = 1'b0;
      done_d  = 1'b0;
    end else if (alloc_i) begin
      alloc_d = 1'b1;
      done_d  = 1'b0;
    end else if (retire_i) begin
      alloc_d = 1'b0;
      done_d  = 1'b0;
    end else if (write_i) begin
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload is qualified by done_q, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (write_i) begin
      result_q <= result_i;
      status_q <= status_i;
    end
  end

  assign alloc_o  = alloc_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign status_o = status_q;

endmodule

// File: rtl/fpnew_rob.sv
// rtl/fpnew_rob.sv - in-order completion tracker around the FPNew tag interface
module fpnew_rob
  import fpnew_wrap_pkg::*;
#(
  parameter int unsigned FLEN         = 64,
  parameter int unsigned TAG_WIDTH    = 2,
  parameter int unsigned STATUS_WIDTH = fpnew_wrap_pkg::STATUS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic                    fpu_in_valid_o,
  input  logic                    fpu_in_ready_i,
  output logic [TAG_WIDTH-1:0]    fpu_tag_o,
  output logic                    fpu_flush_o,
  input  logic                    fpu_out_valid_i,
  output logic                    fpu_out_ready_o,
  input  logic [FLEN-1:0]         fpu_result_i,
  input  logic [STATUS_WIDTH-1:0] fpu_status_i,
  input  logic [TAG_WIDTH-1:0]    fpu_tag_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [FLEN-1:0]         rsp_result_o,
  output logic [STATUS_WIDTH-1:0] rsp_status_o,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned DEPTH = 2 ** TAG_WIDTH;

  typedef logic [TAG_WIDTH:0] ptr_t;

  ptr_t                    head_q, head_d;
  ptr_t                    tail_q, tail_d;
  logic                    err_q, err_d;
  logic [TAG_WIDTH-1:0]    head_idx, tail_idx;
  logic                    empty, full;
  logic                    issue_fire, retire_fire, cpl_ok, cpl_bad;

  logic [DEPTH-1:0]        alloc_w, done_w;
  logic [DEPTH-1:0]        alloc_set, write_en, retire_en;
  logic [FLEN-1:0]         result_w [DEPTH];
  logic [STATUS_WIDTH-1:0] status_w [DEPTH];

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]) && (head_idx == tail_idx);

  assign fpu_in_valid_o  = req_valid_i & ~full & ~flush_i;
  assign req_ready_o     = fpu_in_ready_i & ~full & ~flush_i;
  assign fpu_tag_o       = tail_idx;
  assign fpu_flush_o     = flush_i;
  assign fpu_out_ready_o = 1'b1;
  assign issue_fire      = req_valid_i & req_ready_o;

  // A completion is legal only for an allocated slot still waiting on its result
  assign cpl_ok  = fpu_out_valid_i & ~flush_i & alloc_w[fpu_tag_i] & ~done_w[fpu_tag_i];
  assign cpl_bad = fpu_out_valid_i & ~flush_i & ~(alloc_w[fpu_tag_i] & ~done_w[fpu_tag_i]);

  assign rsp_valid_o  = ~empty & done_w[head_idx] & ~flush_i;
  assign rsp_result_o = result_w[head_idx];
  assign rsp_status_o = status_w[head_idx];
  assign retire_fire  = rsp_valid_o & rsp_ready_i;

  assign busy_o = ~empty;
  assign err_o  = err_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign alloc_set[i] = issue_fire  && (tail_idx  == TAG_WIDTH'(i));
    assign write_en[i]  = cpl_ok      && (fpu_tag_i == TAG_WIDTH'(i));
    assign retire_en[i] = retire_fire && (head_idx  == TAG_WIDTH'(i));

    fpnew_rob_slot #(
      .FLEN         (FLEN),
      .STATUS_WIDTH (STATUS_WIDTH)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .alloc_i  (alloc_set[i]),
      .write_i  (write_en[i]),
      .retire_i (retire_en[i]),
      .result_i (fpu_result_i),
      .status_i (fpu_status_i),
      .alloc_o  (alloc_w[i]),
      .done_o   (done_w[i]),
      .result_o (result_w[i]),
      .status_o (status_w[i])
    );
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q | cpl_bad;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (issue_fire)  tail_d = tail_q + ptr_t'(1);
      if (retire_fire) head_d = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_fpnew_rob.sv
// tb/tb_fpnew_rob.sv - directed self-checking bench for fpnew_rob
module tb_fpnew_rob;
  import fpnew_wrap_pkg::*;

  logic        clk_i, rst_ni;
  logic        req_valid_i, req_ready_o, fpu_in_valid_o, fpu_in_ready_i;
  logic [1:0]  fpu_tag_o, fpu_tag_i;
  logic        fpu_flush_o, fpu_out_valid_i, fpu_out_ready_o;
  logic [63:0] fpu_result_i, rsp_result_o;
  logic [4:0]  fpu_status_i, rsp_status_o;
  logic        rsp_valid_o, rsp_ready_i, flush_i, busy_o, err_o;

  int checks = 0;
  int errors = 0;

  fpnew_rob #(.FLEN(64), .TAG_WIDTH(2), .STATUS_WIDTH(5)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_flush_o     (fpu_flush_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_status_i    (fpu_status_i),
    .fpu_tag_i       (fpu_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_status_o    (rsp_status_o),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rv, ir, fl;
    logic rr, iv, ff;
  } vec_t;

  vec_t    vecs [7];
  status_t st_tab [4];
  int      nops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i     = 1'b0;
    fpu_in_ready_i  = 1'b1;
    fpu_out_valid_i = 1'b0;
    fpu_tag_i       = '0;
    fpu_result_i    = '0;
    fpu_status_i    = '0;
    rsp_ready_i     = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic do_issue(input logic [1:0] exp_tag);
    req_valid_i = 1'b1;
    #1;
    chk("issue_ready", req_ready_o, 1'b1);
    chk("issue_tag", fpu_tag_o, exp_tag);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic do_cpl(input logic [1:0] tag, input logic [63:0] res, input logic [4:0] st);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = tag;
    fpu_result_i    = res;
    fpu_status_i    = st;
    tick();
    fpu_out_valid_i = 1'b0;
  endtask

  task automatic exp_rsp(input string name, input logic [63:0] res, input logic [4:0] st);
    #1;
    chk({name, "_valid"}, rsp_valid_o, 1'b1);
    chk({name, "_result"}, rsp_result_o, res);
    chk({name, "_status"}, rsp_status_o, st);
  endtask

  initial begin
    vecs[0] = '{rv:0, ir:0, fl:0, rr:0, iv:0, ff:0};
    vecs[1] = '{rv:0, ir:1, fl:0, rr:1, iv:0, ff:0};
    vecs[2] = '{rv:1, ir:0, fl:0, rr:0, iv:1, ff:0};
    vecs[3] = '{rv:1, ir:1, fl:0, rr:1, iv:1, ff:0};
    vecs[4] = '{rv:1, ir:1, fl:1, rr:0, iv:0, ff:1};
    vecs[5] = '{rv:0, ir:1, fl:1, rr:0, iv:0, ff:1};
    vecs[6] = '{rv:1, ir:0, fl:1, rr:0, iv:0, ff:1};
    st_tab[0] = status_t'(5'b10000);
    st_tab[1] = status_t'(5'b00001);
    st_tab[2] = status_t'(5'b01000);
    st_tab[3] = status_t'(5'b00110);

    // Reset state
    idle();
    rst_ni = 1'b0;
    fpu_in_ready_i = 1'b0;
    #2;
    chk("rst_req_ready_lo", req_ready_o, 1'b0);
    fpu_in_ready_i = 1'b1;
    #1;
    chk("rst_req_ready_hi", req_ready_o, 1'b1);
    chk("rst_out_ready", fpu_out_ready_o, 1'b1);
    chk("rst_in_valid", fpu_in_valid_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_tag", fpu_tag_o, 2'd0);
    chk("rst_flush", fpu_flush_o, 1'b0);
    #1;
    rst_ni = 1'b1;
    tick();

    // Combinational issue handshake on an empty ROB, no clock edge in between
    for (int i = 0; i < 7; i++) begin
      req_valid_i    = vecs[i].rv;
      fpu_in_ready_i = vecs[i].ir;
      flush_i        = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_req_ready", i), req_ready_o, vecs[i].rr);
      chk($sformatf("vec%0d_in_valid", i), fpu_in_valid_o, vecs[i].iv);
      chk($sformatf("vec%0d_flush", i), fpu_flush_o, vecs[i].ff);
    end
    idle();
    tick();

    // In-order completion
    do_issue(2'd0);
    do_issue(2'd1);
    do_issue(2'd2);
    chk("io_busy", busy_o, 1'b1);
    rsp_ready_i = 1'b1;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 64'h3F80_0000; fpu_status_i = 5'b0;
    #1;
    chk("io_no_bypass", rsp_valid_o, 1'b0);
    tick();
    fpu_tag_i = 2'd1; fpu_result_i = 64'h4000_0000; fpu_status_i = 5'b00001;
    exp_rsp("io_r0", 64'h3F80_0000, 5'b0);
    tick();
    fpu_tag_i = 2'd2; fpu_result_i = 64'h4040_0000; fpu_status_i = 5'b00010;
    exp_rsp("io_r1", 64'h4000_0000, 5'b00001);
    tick();
    fpu_out_valid_i = 1'b0;
    exp_rsp("io_r2", 64'h4040_0000, 5'b00010);
    tick();
    #1;
    chk("io_done_valid", rsp_valid_o, 1'b0);
    chk("io_done_busy", busy_o, 1'b0);
    idle();

    // Out-of-order completion 3,1,2,0
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(2'(i));
    req_valid_i = 1'b1;
    #1;
    chk("ooo_full_ready", req_ready_o, 1'b0);
    chk("ooo_full_in_valid", fpu_in_valid_o, 1'b0);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    do_cpl(2'd3, 64'hA3, st_tab[3]);
    chk("ooo_wait3", rsp_valid_o, 1'b0);
    do_cpl(2'd1, 64'hA1, st_tab[1]);
    chk("ooo_wait1", rsp_valid_o, 1'b0);
    do_cpl(2'd2, 64'hA2, st_tab[2]);
    chk("ooo_wait2", rsp_valid_o, 1'b0);
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 64'hA0; fpu_status_i = st_tab[0];
    #1;
    chk("ooo_wait0", rsp_valid_o, 1'b0);
    tick();
    fpu_out_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rsp($sformatf("ooo_r%0d", i), 64'hA0 + 64'(i), st_tab[i]);
      tick();
    end
    #1;
    chk("ooo_end_valid", rsp_valid_o, 1'b0);
    chk("ooo_end_busy", busy_o, 1'b0);
    idle();

    // Full, backpressure and wrap-around
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(2'(i));
    req_valid_i = 1'b1;
    #1;
    chk("full_req_ready", req_ready_o, 1'b0);
    chk("full_in_valid", fpu_in_valid_o, 1'b0);
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) do_cpl(2'(i), 64'h100 + 64'(i), 5'b0);
    rsp_ready_i = 1'b1;
    exp_rsp("wrap_r0", 64'h100, 5'b0);
    tick();
    rsp_ready_i = 1'b0;
    do_issue(2'd0);
    req_valid_i = 1'b1;
    #1;
    chk("wrap_full_again", req_ready_o, 1'b0);
    req_valid_i = 1'b0;
    do_cpl(2'd0, 64'h104, 5'b0);
    rsp_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_rsp($sformatf("wrap_r%0d", i), 64'h100 + 64'(i), 5'b0);
      tick();
    end
    rsp_ready_i = 1'b0;
    nops = 5;
    for (int b = 0; b < 5; b++) begin
      int base;
      int ord [4];
      base = nops;
      ord = '{2, 0, 3, 1};
      for (int k = 0; k < 4; k++) begin
        do_issue(2'(nops));
        nops++;
      end
      for (int k = 0; k < 4; k++)
        do_cpl(2'(base + ord[k]), 64'h200 + 64'(base + ord[k]), 5'(base + ord[k]));
      rsp_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_rsp($sformatf("run_op%0d", base + k), 64'h200 + 64'(base + k), 5'(base + k));
        tick();
      end
      rsp_ready_i = 1'b0;
    end
    #1;
    chk("run_end_valid", rsp_valid_o, 1'b0);
    chk("run_end_busy", busy_o, 1'b0);
    chk("run_err", err_o, 1'b0);
    idle();

    // Simultaneous retire, completion and issue
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(2'(i));
    do_cpl(2'd0, 64'hC0, 5'b0);
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_result_i = 64'hC1; fpu_status_i = 5'b00100;
    exp_rsp("sim_r0", 64'hC0, 5'b0);
    chk("sim_ready", req_ready_o, 1'b1);
    chk("sim_tag", fpu_tag_o, 2'd3);
    tick();
    idle();
    exp_rsp("sim_r1_ready", 64'hC1, 5'b00100);
    do_issue(2'd0);
    req_valid_i = 1'b1;
    #1;
    chk("sim_count_full", req_ready_o, 1'b0);
    req_valid_i = 1'b0;
    do_cpl(2'd2, 64'hC2, 5'b0);
    do_cpl(2'd3, 64'hC3, 5'b0);
    do_cpl(2'd0, 64'hC4, 5'b0);
    rsp_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_rsp($sformatf("sim_d%0d", i), 64'hC0 + 64'(i), (i == 1) ? 5'b00100 : 5'b0);
      tick();
    end
    #1;
    chk("sim_end_busy", busy_o, 1'b0);
    idle();

    // Flush with three in flight, one done
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(2'(i));
    do_cpl(2'd0, 64'hD0, 5'b0);
    #1;
    chk("fl_pre_valid", rsp_valid_o, 1'b1);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd2; fpu_result_i = 64'hD2;
    #1;
    chk("fl_flush_o", fpu_flush_o, 1'b1);
    chk("fl_rsp_valid", rsp_valid_o, 1'b0);
    chk("fl_in_valid", fpu_in_valid_o, 1'b0);
    tick();
    idle();
    #1;
    chk("fl_busy", busy_o, 1'b0);
    chk("fl_valid_after", rsp_valid_o, 1'b0);
    chk("fl_err", err_o, 1'b0);
    chk("fl_tag", fpu_tag_o, 2'd0);

    // Spurious completion, then asynchronous reset mid-operation
    do_cpl(2'd2, 64'hEE, 5'b0);
    chk("sp_err", err_o, 1'b1);
    chk("sp_valid", rsp_valid_o, 1'b0);
    chk("sp_busy", busy_o, 1'b0);
    do_issue(2'd0);
    do_cpl(2'd0, 64'hE0, 5'b0);
    exp_rsp("sp_after", 64'hE0, 5'b0);
    chk("sp_sticky", err_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_err", err_o, 1'b0);
    chk("ar_busy", busy_o, 1'b0);
    chk("ar_valid", rsp_valid_o, 1'b0);
    #2;
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
